// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between split I/D requesters, the arbiter and physical memory
//
// Groups every handshake and data signal around the arbiter.
//   slave  : the arbiter's view. It takes the I/D requests and pmem_rdata/pmem_resp,
//            and drives the I/D read data, the completions and the pmem strobes.
//   master : the environment's view (requesters plus physical memory), the mirror of slave.
// Signals:
//   i_mem_read, i_mem_address[15:0]                   I-side request (level-held)
//   i_mem_rdata[15:0], i_mem_resp                     I-side response
//   d_mem_read, d_mem_write, d_mem_byte_enable[1:0],
//   d_mem_address[15:0], d_mem_wdata[15:0]            D-side request (level-held)
//   d_mem_rdata[15:0], d_mem_resp                     D-side response
//   pmem_read, pmem_write, pmem_byte_enable[1:0],
//   pmem_address[15:0], pmem_wdata[15:0]              physical memory command
//   pmem_rdata[15:0], pmem_resp                       physical memory response
interface mem_arbiter_if;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic [15:0] i_mem_rdata;
    logic        i_mem_resp;

    logic        d_mem_read;
    logic        d_mem_write;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic [15:0] d_mem_rdata;
    logic        d_mem_resp;

    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  i_mem_read, i_mem_address,
        output i_mem_rdata, i_mem_resp,
        input  d_mem_read, d_mem_write, d_mem_byte_enable, d_mem_address, d_mem_wdata,
        output d_mem_rdata, d_mem_resp,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_mem_read, i_mem_address,
        input  i_mem_rdata, i_mem_resp,
        output d_mem_read, d_mem_write, d_mem_byte_enable, d_mem_address, d_mem_wdata,
        input  d_mem_rdata, d_mem_resp,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one physical memory port between the I-fetch and data requesters
//
// One transaction is in flight at a time. When a request is granted in IDLE, its address,
// write data, mask and op are captured into holding registers. The pmem command is driven
// only from those registers and the state, so requester inputs never reach pmem_*
// combinationally. The owner's completion is pmem_resp passed through in the same cycle.
// D has priority over I.
//
// Optional feature: define MEM_ARB_FAIRNESS_EN to add a starvation counter. After
// STARVE_LIMIT consecutive D grants made while I was waiting, I gets the port.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mem_arbiter_if.slave (I/D requester sides and physical memory side)
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        write_q, write_d;

    logic        d_req;
    logic        grant_d;
    logic        grant_i;
    logic        starve_hit;
    logic        busy;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == CW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            // The count tracks an I request that keeps losing. It restarts once I is
            // served or stops asking, and it saturates so it cannot wrap back to zero.
            if (!bus.i_mem_read || grant_i) begin
                starve_d = '0;
            end else if (grant_d && !starve_hit) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Fixed D priority. This is never true for a legal limit, so I can starve.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

    assign d_req = bus.d_mem_read | bus.d_mem_write;

    always_comb begin
        grant_d = (state_q == IDLE) && d_req && !(starve_hit && bus.i_mem_read);
        grant_i = (state_q == IDLE) && bus.i_mem_read && !grant_d;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = bus.d_mem_address;
                    wdata_d = bus.d_mem_wdata;
                    // A read+write request is treated as a write.
                    write_d = bus.d_mem_write;
                    be_d    = bus.d_mem_write ? bus.d_mem_byte_enable : 2'b11;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                    addr_d  = bus.i_mem_address;
                    wdata_d = '0;
                    write_d = 1'b0;
                    be_d    = 2'b11;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 2'b11;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    assign busy = (state_q != IDLE);

    assign bus.pmem_read        = busy & ~write_q;
    assign bus.pmem_write       = busy & write_q;
    assign bus.pmem_byte_enable = be_q;
    assign bus.pmem_address     = addr_q;
    assign bus.pmem_wdata       = wdata_q;

    // Read data goes to both sides while busy. Only the owner sees a completion.
    assign bus.i_mem_rdata = busy ? bus.pmem_rdata : 16'h0000;
    assign bus.d_mem_rdata = busy ? bus.pmem_rdata : 16'h0000;
    assign bus.i_mem_resp  = (state_q == I_BUSY) & bus.pmem_resp;
    assign bus.d_mem_resp  = (state_q == D_BUSY) & bus.pmem_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int LIMIT = 2;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_mem_read        = 1'b0;
        bus.i_mem_address     = 16'h0000;
        bus.d_mem_read        = 1'b0;
        bus.d_mem_write       = 1'b0;
        bus.d_mem_byte_enable = 2'b00;
        bus.d_mem_address     = 16'h0000;
        bus.d_mem_wdata       = 16'h0000;
        bus.pmem_rdata        = 16'h0000;
        bus.pmem_resp         = 1'b0;
    endtask

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        logic        e_read;
        logic        e_write;
        logic [1:0]  e_be;
    } vec_t;

    vec_t vt[5];

    task automatic run_vec(input int n, input vec_t v);
        if (v.is_d) begin
            bus.d_mem_read        = v.rd;
            bus.d_mem_write       = v.wr;
            bus.d_mem_byte_enable = v.be;
            bus.d_mem_address     = v.addr;
            bus.d_mem_wdata       = v.wdata;
        end else begin
            bus.i_mem_read    = 1'b1;
            bus.i_mem_address = v.addr;
        end
        #1;
        chk($sformatf("v%0d_no_comb_strobe", n), {bus.pmem_read, bus.pmem_write}, 2'b00);
        step();
        chk($sformatf("v%0d_read", n), bus.pmem_read, v.e_read);
        chk($sformatf("v%0d_write", n), bus.pmem_write, v.e_write);
        chk($sformatf("v%0d_be", n), bus.pmem_byte_enable, v.e_be);
        chk($sformatf("v%0d_addr", n), bus.pmem_address, v.addr);
        if (v.e_write) chk($sformatf("v%0d_wdata", n), bus.pmem_wdata, v.wdata);
        // Requester inputs move mid-transaction; the command must not follow them.
        if (v.is_d) begin
            bus.d_mem_wdata   = ~v.wdata;
            bus.d_mem_address = ~v.addr;
        end else begin
            bus.i_mem_address = ~v.addr;
        end
        repeat (v.lat) step();
        bus.pmem_rdata = v.rdata;
        bus.pmem_resp  = 1'b1;
        #1;
        chk($sformatf("v%0d_own_resp", n), v.is_d ? bus.d_mem_resp : bus.i_mem_resp, 1'b1);
        chk($sformatf("v%0d_other_resp", n), v.is_d ? bus.i_mem_resp : bus.d_mem_resp, 1'b0);
        chk($sformatf("v%0d_rdata", n), v.is_d ? bus.d_mem_rdata : bus.i_mem_rdata, v.rdata);
        chk($sformatf("v%0d_addr_hold", n), bus.pmem_address, v.addr);
        if (v.e_write) chk($sformatf("v%0d_wdata_hold", n), bus.pmem_wdata, v.wdata);
        step();
        bus.pmem_resp = 1'b0;
        clear_inputs();
        chk($sformatf("v%0d_release", n), {bus.pmem_read, bus.pmem_write, bus.i_mem_resp, bus.d_mem_resp}, 4'b0000);
    endtask

    // Random-phase state: pending requests, the expected in-flight command, two memories.
    logic [15:0] ref_mem [256];
    logic [15:0] phy_mem [256];
    bit          i_pend, d_pend, d_wr, busy_ph, resp_given, own_d, strobe, e_wr;
    logic [15:0] i_addr, d_addr, d_wdata, e_addr, e_wdata, rd_val;
    logic [1:0]  d_be, e_be;
    int          wait_cnt, starve, op;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
        return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
    endfunction

    initial begin
        //           is_d rd   wr   be     addr     wdata    rdata    lat rd   wr   e_be
        vt[0] = '{1'b0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h1234, 3, 1'b1, 1'b0, 2'b11};
        vt[1] = '{1'b1, 1'b0, 1'b1, 2'b10, 16'h0021, 16'hAB00, 16'h0000, 2, 1'b0, 1'b1, 2'b10};
        vt[2] = '{1'b1, 1'b1, 1'b0, 2'b01, 16'h0040, 16'h0000, 16'hBEEF, 1, 1'b1, 1'b0, 2'b11};
        vt[3] = '{1'b1, 1'b1, 1'b1, 2'b01, 16'h0100, 16'h00CD, 16'h0000, 0, 1'b0, 1'b1, 2'b01};
        vt[4] = '{1'b0, 1'b1, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 1'b1, 1'b0, 2'b11};

        clear_inputs();
        reset_n = 1'b0;
        bus.pmem_rdata = 16'hA5A5;
        #12;
        chk("rst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("rst_be", bus.pmem_byte_enable, 2'b11);
        chk("rst_addr", bus.pmem_address, 16'h0000);
        chk("rst_wdata", bus.pmem_wdata, 16'h0000);
        chk("rst_resps", {bus.i_mem_resp, bus.d_mem_resp}, 2'b00);
        chk("rst_rdata", {bus.i_mem_rdata, bus.d_mem_rdata}, 32'h0);
        bus.pmem_rdata = 16'h0000;
        reset_n = 1'b1;
        step();

        for (int n = 0; n < 5; n++) run_vec(n, vt[n]);

        // Simultaneous I and D: D first, one idle cycle, then I.
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h0080;
        bus.d_mem_read    = 1'b1;
        bus.d_mem_address = 16'h0040;
        step();
        chk("sim_d_addr", bus.pmem_address, 16'h0040);
        chk("sim_d_read", bus.pmem_read, 1'b1);
        bus.pmem_rdata = 16'h5555;
        bus.pmem_resp  = 1'b1;
        #1;
        chk("sim_d_resp", {bus.d_mem_resp, bus.i_mem_resp}, 2'b10);
        step();
        bus.pmem_resp  = 1'b0;
        bus.d_mem_read = 1'b0;
        chk("sim_gap", {bus.pmem_read, bus.pmem_write}, 2'b00);
        step();
        chk("sim_i_addr", bus.pmem_address, 16'h0080);
        chk("sim_i_read", bus.pmem_read, 1'b1);
        bus.pmem_resp = 1'b1;
        #1;
        chk("sim_i_resp", {bus.d_mem_resp, bus.i_mem_resp}, 2'b01);
        step();
        clear_inputs();

        // Both sides request without pause; grant order depends on the fairness build.
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h0100;
        bus.d_mem_read    = 1'b1;
        bus.d_mem_address = 16'h0D00;
        starve = 0;
        for (int g = 0; g < 6; g++) begin
            bit exp_i;
            exp_i = FAIR && (starve == LIMIT);
            starve = exp_i ? 0 : starve + 1;
            step();
            chk($sformatf("fair_grant%0d", g), bus.pmem_address, exp_i ? 16'h0100 : 16'h0D00);
            bus.pmem_resp = 1'b1;
            step();
            bus.pmem_resp = 1'b0;
        end
        clear_inputs();
        step();

        // Reset during D_BUSY aborts the write without a completion.
        bus.d_mem_write       = 1'b1;
        bus.d_mem_byte_enable = 2'b01;
        bus.d_mem_address     = 16'h0033;
        bus.d_mem_wdata       = 16'h00EE;
        step();
        chk("rmid_busy", bus.pmem_write, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmid_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("rmid_addr", bus.pmem_address, 16'h0000);
        bus.pmem_resp = 1'b1;
        #1;
        chk("rmid_no_resp", bus.d_mem_resp, 1'b0);
        clear_inputs();
        step();
        reset_n = 1'b1;
        step();
        chk("rmid_idle", {bus.pmem_read, bus.pmem_write, bus.d_mem_resp}, 3'b000);

        // Randomized traffic against a transaction-level model.
        for (int k = 0; k < 256; k++) begin
            ref_mem[k] = 16'($urandom);
            phy_mem[k] = ref_mem[k];
        end
        i_pend = 0; d_pend = 0; busy_ph = 0; resp_given = 0; starve = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            strobe = bus.pmem_read | bus.pmem_write;
            if (!busy_ph) begin
                if (i_pend || d_pend) begin
                    own_d = d_pend && !(FAIR && starve == LIMIT && i_pend);
                    if (!i_pend || !own_d) starve = 0;
                    else if (starve < LIMIT) starve++;
                    e_wr    = own_d && d_wr;
                    e_addr  = own_d ? d_addr : i_addr;
                    e_be    = e_wr ? d_be : 2'b11;
                    e_wdata = d_wdata;
                    busy_ph = 1; resp_given = 0;
                    wait_cnt = $urandom_range(0, 3);
                    chk("rnd_grant", strobe, 1'b1);
                end else begin
                    starve = 0;
                    chk("rnd_idle", strobe, 1'b0);
                end
            end
            if (busy_ph) begin
                if (resp_given) begin
                    chk("rnd_release", strobe, 1'b0);
                    bus.pmem_resp = 1'b0;
                    if (own_d) begin
                        if (e_wr) ref_mem[e_addr[7:0]] = merge(ref_mem[e_addr[7:0]], e_wdata, e_be);
                        d_pend = 0;
                        bus.d_mem_read  = 1'b0;
                        bus.d_mem_write = 1'b0;
                    end else begin
                        i_pend = 0;
                        bus.i_mem_read = 1'b0;
                    end
                    busy_ph = 0;
                end else begin
                    chk("rnd_addr", bus.pmem_address, e_addr);
                    chk("rnd_op", {bus.pmem_read, bus.pmem_write}, {!e_wr, e_wr});
                    chk("rnd_be", bus.pmem_byte_enable, e_be);
                    if (e_wr) chk("rnd_wdata", bus.pmem_wdata, e_wdata);
                    if (wait_cnt == 0) begin
                        if (bus.pmem_write) begin
                            phy_mem[bus.pmem_address[7:0]] = merge(phy_mem[bus.pmem_address[7:0]],
                                                                   bus.pmem_wdata, bus.pmem_byte_enable);
                            rd_val = 16'($urandom);
                        end else begin
                            rd_val = phy_mem[bus.pmem_address[7:0]];
                        end
                        bus.pmem_rdata = rd_val;
                        bus.pmem_resp  = 1'b1;
                        #1;
                        chk("rnd_own_resp", own_d ? bus.d_mem_resp : bus.i_mem_resp, 1'b1);
                        chk("rnd_other_resp", own_d ? bus.i_mem_resp : bus.d_mem_resp, 1'b0);
                        chk("rnd_other_rdata", own_d ? bus.i_mem_rdata : bus.d_mem_rdata, rd_val);
                        if (!e_wr) chk("rnd_rdata", own_d ? bus.d_mem_rdata : bus.i_mem_rdata,
                                       ref_mem[e_addr[7:0]]);
                        resp_given = 1;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                i_addr = 16'($urandom);
                bus.i_mem_read    = 1'b1;
                bus.i_mem_address = i_addr;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend  = 1;
                op      = $urandom_range(0, 2);
                d_wr    = (op != 0);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
                d_be    = 2'($urandom);
                bus.d_mem_read        = (op != 1);
                bus.d_mem_write       = (op != 0);
                bus.d_mem_address     = d_addr;
                bus.d_mem_wdata       = d_wdata;
                bus.d_mem_byte_enable = d_be;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter that shares a single physical memory port between the instruction-fetch requester and the data requester of the LC-3b core. It sits between the split I/D memory interfaces and the unified physical memory. It latches one transaction at a time and forwards it to physical memory. It then routes the response back to the requester that owns the grant.

## Interface
- STARVE_LIMIT, 4: maximum consecutive D-side grants while the I-side waits (fairness mode only); range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_mem_read  in  1  I-side read request; held high until i_mem_resp.
- i_mem_address  in  16  I-side word address (lc3b_word).
- i_mem_rdata  out  16  I-side read data; valid when i_mem_resp=1.
- i_mem_resp  out  1  I-side completion, one-cycle pulse.
- d_mem_read  in  1  D-side read request; held until d_mem_resp.
- d_mem_write  in  1  D-side write request; held until d_mem_resp.
- d_mem_byte_enable  in  2  D-side write mask (lc3b_mem_wmask).
- d_mem_address  in  16  D-side address.
- d_mem_wdata  in  16  D-side write data.
- d_mem_rdata  out  16  D-side read data; valid when d_mem_resp=1.
- d_mem_resp  out  1  D-side completion, one-cycle pulse.
- pmem_read / pmem_write  out  1 each  physical memory strobes.
- pmem_byte_enable  out  2  physical write mask.
- pmem_address / pmem_wdata  out  16 each  physical address and write data.
- pmem_rdata  in  16  physical read data.
- pmem_resp  in  1  physical completion.

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - Evaluate requests each cycle and grant one.
  - On grant, latch address, wdata, mask and op (read/write) into holding registers, then go to I_BUSY or D_BUSY.
  - If there is no request, stay in IDLE.
- Priority: D over I by default, so the load/store stage is not stalled behind fetch.
- I_BUSY / D_BUSY:
  - Drive pmem_* from the holding registers.
  - Route pmem_rdata to both rdata outputs.
  - Assert the owner's resp = pmem_resp combinationally.
  - The non-owner's resp is 0.
  - On pmem_resp=1, return to IDLE.
- I-side grants are always reads. pmem_byte_enable=2'b11 for every read.
- D-side: if d_mem_read and d_mem_write are both high (illegal), the write wins.
- If a requester drops its request before resp, the latched transaction still completes and the resp pulse is still issued. The requester ignores it.
- Requests arriving while busy wait. They are not queued beyond the level-held request.

## Timing
- Reset (async, reset_n=0):
  - state=IDLE.
  - pmem_read=0, pmem_write=0, pmem_byte_enable=2'b11.
  - pmem_address=0, pmem_wdata=0.
  - i_mem_resp=0, d_mem_resp=0. rdata outputs are 0.
  - Starvation counter=0.
- Reset mid-transaction aborts it. No resp is issued.
- Latency: a request seen in IDLE at cycle N produces a pmem strobe from cycle N+1. pmem strobes come from registered state and holding registers, with no combinational path from requester inputs.
- Response: pmem_resp at cycle M gives the owner's resp at cycle M (same cycle). The strobe is deasserted at M+1 (state=IDLE). The earliest next grant is decided in M+1 and strobed at M+2.
- Minimum back-to-back turnaround is one idle cycle between pmem transactions.
- Holding registers are stable for the whole busy period, independent of requester inputs.

## Configuration
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined (fairness on):
  - A starvation counter of $clog2(STARVE_LIMIT+1) bits exists.
  - It increments on each D grant made while i_mem_read=1.
  - It clears on each I grant, and when i_mem_read=0 in IDLE.
  - When the counter equals STARVE_LIMIT and both sides request, I is granted.
  - The counter saturates at STARVE_LIMIT; it never wraps.
- Undefined: fixed D priority with no counter. I can be starved indefinitely.

## Test plan
- I-read alone:
  - Stimulus: i_mem_read=1, addr=0x0010, pmem_resp after 3 cycles with rdata=0x1234.
  - Required response: pmem_read is high from N+1; i_mem_resp pulses once with i_mem_rdata=0x1234; pmem_read is low the next cycle.
- Simultaneous I and D requests:
  - Stimulus: i_mem_read=1 and d_mem_read=1 (d addr=0x0040) in the same cycle.
  - Required response: D is served first (pmem_address=0x0040). I is served after one idle cycle. There is no resp pulse to the non-owner.
- D byte write:
  - Stimulus: d_mem_write=1, mask=2'b10, wdata=0xAB00, addr=0x0021.
  - Required response: pmem_write=1, pmem_byte_enable=2'b10, pmem_wdata=0xAB00. Changing d_mem_wdata mid-transaction does not alter pmem_wdata.
- Fairness (macro defined, STARVE_LIMIT=2):
  - Stimulus: D requests continuously while I requests continuously.
  - Required response: grant order D, D, I, D, D, I.
  - Without the macro, only D grants appear.
- Reset mid-op:
  - Stimulus: reset_n=0 during D_BUSY, before pmem_resp.
  - Required response: pmem_write=0 immediately (asynchronously). d_mem_resp is never pulsed. After release, state=IDLE.
- Illegal D read+write:
  - Stimulus: d_mem_read=1 and d_mem_write=1.
  - Required response: the transaction is issued as pmem_write with the supplied mask.
